// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - CPU request/response and data_mem port bundle for the LSU
interface dmem_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] addr_dmem_ram_o;
  logic [31:0] wr_data_dmem_ram_o;
  logic        wr_en_dmem_ram_o;
  logic [31:0] read_data_dmem_ram_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  read_data_dmem_ram_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output addr_dmem_ram_o, wr_data_dmem_ram_o, wr_en_dmem_ram_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output read_data_dmem_ram_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  addr_dmem_ram_o, wr_data_dmem_ram_o, wr_en_dmem_ram_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module dmem_lsu #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] req_widx;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;
  logic [31:0] merged;
  logic [4:0]  lane_shift;

  assign accept   = bus.req_valid_i && (state == S_IDLE);
  assign req_widx = {2'b00, bus.req_addr_i[31:2]};

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size_i == 2'd3)
      req_err = 1'b1;
    else if (bus.req_size_i == 2'd1 && bus.req_addr_i[0])
      req_err = 1'b1;
    else if (bus.req_size_i == 2'd2 && bus.req_addr_i[1:0] != 2'b00)
      req_err = 1'b1;
    else if (req_widx >= MEM_WORDS)
      req_err = 1'b1;
  end

  // Little-endian lane selection from the combinational read word.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_lane = bus.read_data_dmem_ram_i[7:0];
      2'd1: byte_lane = bus.read_data_dmem_ram_i[15:8];
      2'd2: byte_lane = bus.read_data_dmem_ram_i[23:16];
      default: byte_lane = bus.read_data_dmem_ram_i[31:24];
    endcase
  end

  assign half_lane = addr_q[1] ? bus.read_data_dmem_ram_i[31:16] : bus.read_data_dmem_ram_i[15:0];

  always_comb begin
    load_val = bus.read_data_dmem_ram_i;
    case (size_q)
      2'd0: load_val = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      2'd1: load_val = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: load_val = bus.read_data_dmem_ram_i;
    endcase
  end

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_mask  = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign lane_ins   = (wdata_q << lane_shift) & lane_mask;
  assign merged     = (bus.read_data_dmem_ram_i & ~lane_mask) | lane_ins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            size_q  <= bus.req_size_i;
            we_q    <= bus.req_we_i;
            uns_q   <= bus.req_unsigned_i;
            data_q  <= 32'h0;
            err_q   <= req_err;
            if (req_err)
              state <= S_RESP;
            else if (!bus.req_we_i)
              state <= S_LOAD;
            else if (bus.req_size_i == 2'd2)
              state <= S_WRITE;
            else
              state <= S_MERGE;
          end
        end
        S_LOAD: begin
          data_q <= load_val;
          state  <= S_RESP;
        end
        S_MERGE: begin
          data_q <= merged;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          // Store responses carry no data, so drop the merged word here.
          data_q <= 32'h0;
          state  <= S_RESP;
        end
        S_RESP: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o        = (state == S_IDLE);
  assign bus.addr_dmem_ram_o    = (state != S_IDLE) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign bus.wr_en_dmem_ram_o   = (state == S_WRITE);
  assign bus.wr_data_dmem_ram_o = (state != S_WRITE) ? 32'h0 :
                                  (size_q == 2'd2) ? wdata_q : data_q;
  assign bus.resp_valid_o       = (state == S_RESP);
  assign bus.resp_rdata_o       = (state == S_RESP) ? data_q : 32'h0;
  assign bus.resp_err_o         = (state == S_RESP) && err_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a word-array model
module tb_dmem_lsu;
  localparam int MW = 1024;

  logic clk;
  logic rst_n;
  logic init_go;

  dmem_lsu_if bus ();

  dmem_lsu #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_resp   = 0;
  int n_accept = 0;
  int n_viol   = 0;

  assign bus.read_data_dmem_ram_i = (bus.addr_dmem_ram_o < MW) ? mem[bus.addr_dmem_ram_o[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < MW; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
    end else if (bus.wr_en_dmem_ram_o) begin
      if (bus.addr_dmem_ram_o < MW) mem[bus.addr_dmem_ram_o[9:0]] <= bus.wr_data_dmem_ram_o;
      n_writes <= n_writes + 1;
    end
    if (rst_n && bus.req_valid_i && bus.req_ready_o) n_accept <= n_accept + 1;
  end

  always @(negedge clk) begin
    if (bus.resp_valid_o) n_resp <= n_resp + 1;
    if (!bus.wr_en_dmem_ram_o && bus.wr_data_dmem_ram_o != 32'h0) n_viol <= n_viol + 1;
    if (!bus.resp_valid_o && (bus.resp_rdata_o != 32'h0 || bus.resp_err_o)) n_viol <= n_viol + 1;
    if (bus.req_ready_o && bus.addr_dmem_ram_o != 32'h0) n_viol <= n_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outcome computed straight from the access rules on a plain word array.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat, output int nw);
    int unsigned idx, lane;
    logic [31:0] w, v;
    idx = a / 4;
    rd = 0; nw = 0;
    e = (size == 3) || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0) || (idx >= MW);
    if (e) begin
      lat = 1;
      return;
    end
    w = ref_mem[idx];
    if (!we) begin
      lat = 2;
      if (size == 0) begin
        lane = a % 4;
        v = (w / (32'h1 << (8 * lane))) % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        rd = v;
      end else if (size == 1) begin
        lane = (a % 4) / 2;
        v = (w / (32'h1 << (16 * lane))) % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        rd = v;
      end else rd = w;
    end else begin
      nw = 1;
      if (size == 2) begin
        lat = 2;
        ref_mem[idx] = wd;
      end else if (size == 0) begin
        lane = a % 4;
        lat = 3;
        v = w - (((w / (32'h1 << (8 * lane))) % 256) * (32'h1 << (8 * lane)));
        ref_mem[idx] = v + (wd % 256) * (32'h1 << (8 * lane));
      end else begin
        lane = (a % 4) / 2;
        lat = 3;
        v = w - (((w / (32'h1 << (16 * lane))) % 65536) * (32'h1 << (16 * lane)));
        ref_mem[idx] = v + (wd % 65536) * (32'h1 << (16 * lane));
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] erd;
    logic ee;
    int elat, enw, lat, w0;
    model(we, size, uns, a, wd, erd, ee, elat, enw);
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready_o), 32'd1);
    drive(we, size, uns, a, wd);
    w0 = n_writes;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".rdata"}, bus.resp_rdata_o, erd);
    check({tag, ".err"}, 32'(bus.resp_err_o), 32'(ee));
    check({tag, ".writes"}, 32'(n_writes - w0), 32'(enw));
    if (a / 4 < MW) check({tag, ".mem"}, mem[a / 4], ref_mem[a / 4]);
  endtask

  initial begin
    logic [31:0] erd, a;
    logic ee;
    int elat, enw, w0, r0;
    logic [1:0] sz;

    for (int i = 0; i < MW; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    bus.req_valid_i = 1'b0;
    init_go = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 init_go = 1'b0;
    @(negedge clk);
    check("reset.ready", 32'(bus.req_ready_o), 32'd1);
    check("reset.resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("reset.wr_en", 32'(bus.wr_en_dmem_ram_o), 32'd0);
    check("reset.addr", bus.addr_dmem_ram_o, 32'd0);
    rst_n = 1'b1;

    xact("t1_sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    xact("t1_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    xact("t2_sb", 1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    check("t2.word", mem[4], 32'hDEAD_55EF);
    xact("t3_sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
    xact("t3_lb", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    xact("t3_lbu", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    xact("t3_lh0", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    xact("t3_lh2", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    xact("t4_mis", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    xact("t4_oor", 1'b1, 2'd2, 1'b0, 32'h1002, 32'h1234_5678);
    xact("t4_oor_al", 1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678);
    xact("t4_sz3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    xact("t4_last", 1'b1, 2'd1, 1'b0, 32'hFFE, 32'hA5A5_C3C3);

    // Back-to-back: valid held high across three word loads.
    @(negedge clk);
    r0 = n_accept;
    for (int i = 0; i < 3; i++) begin
      a = 32'h20 + 32'(i) * 4;
      model(1'b0, 2'd2, 1'b0, a, 32'h0, erd, ee, elat, enw);
      drive(1'b0, 2'd2, 1'b0, a, 32'h0);
      @(negedge clk);
      check("b2b.ready_low", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
      check("b2b.resp", 32'(bus.resp_valid_o), 32'd1);
      check("b2b.ready_resp", 32'(bus.req_ready_o), 32'd0);
      check("b2b.rdata", bus.resp_rdata_o, erd);
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("b2b.accepts", 32'(n_accept - r0), 32'd3);

    // Reset during MERGE of a byte store.
    w0 = n_writes;
    r0 = n_resp;
    a = mem[8];
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h21, 32'h77);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.wr_en", 32'(bus.wr_en_dmem_ram_o), 32'd0);
    check("rst.resp", 32'(bus.resp_valid_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(bus.req_ready_o), 32'd1);
    check("rst.mem", mem[8], a);
    check("rst.writes", 32'(n_writes - w0), 32'd0);
    check("rst.no_resp", 32'(n_resp - r0), 32'd0);

    for (int i = 0; i < 250; i++) begin
      sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MW, MW + 64)) * 4;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) * 4;
      else a = 32'($urandom_range(0, MW - 1)) * 4;
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      else if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
      else if (sz == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
      xact("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    check("invariants", 32'(n_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator between the CPU execute stage and the word-wide data_mem responder. It accepts byte, halfword and word load/store requests over a valid/ready handshake. It drives the data_mem port, which has a single write enable and no byte enables, so sub-word stores are done as a read-modify-write sequence. Each request returns one response carrying load data, aligned and sign- or zero-extended, or an error flag.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in data_mem; any word index >= MEM_WORDS is an out-of-range error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  LSU can accept a request
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-justified
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  32  load result; 0 for stores and errors
resp_err_o  output  1  misaligned, illegal size or out of range
addr_dmem_ram_o  output  32  word index to data_mem: {2'b00, addr[31:2]}
wr_data_dmem_ram_o  output  32  write word to data_mem
wr_en_dmem_ram_i is not used; the write enable is wr_en_dmem_ram_o  output  1  data_mem write enable
read_data_dmem_ram_i  input  32  data_mem combinational read data

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs are 0 except req_ready_o, which is 1. Internal latches are cleared.
- A reset asserted mid-operation aborts the operation immediately:
  - wr_en_dmem_ram_o drops at once.
  - No response is issued.
  - A partially merged store is never written.
- Handshake: a request is accepted when req_valid_i and req_ready_o are both high at a rising edge.
  - At acceptance, addr, we, size, unsigned and wdata are latched.
  - req_ready_o is 1 only in IDLE, so only one request is outstanding.
  - Responses have no backpressure.
- Error check at acceptance, in priority order:
  - size == 3 is illegal.
  - Misaligned: a halfword with addr[0] != 0, or a word with addr[1:0] != 0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - On error: go to RESP with err = 1 and rdata = 0. data_mem is never accessed and no write occurs.
- States and transitions:
  - IDLE: on accept, go to ERR-path RESP if the error check fails. Otherwise a load goes to LOAD, a word store goes to WRITE, and a byte or halfword store goes to MERGE.
  - LOAD: drive the word index and sample read_data_dmem_ram_i. Extract the lane, extend it, register it into rdata, then go to RESP.
  - MERGE: drive the word index and sample the read word. Replace the addressed byte lane(s) with the low byte/halfword of wdata, register the merged word, then go to WRITE.
  - WRITE: drive the word index, drive wr_data (full wdata for word stores, merged word otherwise) and set wr_en_dmem_ram_o = 1 for exactly this cycle. Then go to RESP.
  - RESP: resp_valid_o = 1 for one cycle, then go to IDLE.
- Lane mapping is little-endian.
  - Byte: lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Halfword: lane = addr[1], bits [16*lane+15 : 16*lane].
  - Sign-extension copies bit 7 (byte) or bit 15 (halfword) when req_unsigned_i = 0.
  - Word loads ignore req_unsigned_i.
- Latency, counted from acceptance edge T, as the edge at which resp_valid_o is seen high:
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
  - A new request can be accepted on the edge after RESP.
- addr_dmem_ram_o holds the latched word index in every non-IDLE state and is 0 in IDLE.
- wr_data_dmem_ram_o is 0 whenever wr_en_dmem_ram_o = 0.
- resp_rdata_o and resp_err_o are 0 whenever resp_valid_o = 0.

Test Plan:
1. Word store addr 0x10, data 0xDEADBEEF -> wr_en for one cycle, index 0x4, data 0xDEADBEEF, resp at T+2 with err 0. Then word load 0x10 -> rdata 0xDEADBEEF at T+2.
2. Memory word 4 = 0xDEADBEEF; byte store addr 0x11, data 0x55 -> MERGE, then write 0xDEAD55EF at T+2, resp at T+3. Word 4 reads back 0xDEAD55EF.
3. Word 4 = 0x80FF7F01, then four loads:
   - Signed byte load 0x13 -> 0xFFFFFF80.
   - Unsigned byte load 0x13 -> 0x00000080.
   - Signed half load 0x10 -> 0x00007F01.
   - Signed half load 0x12 -> 0xFFFF80FF.
4. Error requests:
   - Half load at 0x11 -> resp at T+1 with err 1, rdata 0, wr_en never high.
   - Word store at 0x1002 (MEM_WORDS=1024) -> err 1, no write.
   - size 3 -> err 1.
5. Back-to-back: hold req_valid_i high for 3 word loads -> req_ready_o low during LOAD/RESP, each request accepted exactly once, responses in order.
6. Reset mid-operation: assert rst_n low during MERGE of a byte store -> wr_en stays 0, memory unchanged, no resp_valid_o, req_ready_o = 1 after release.
